// File: rtl/sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl
//
// Simulation run controller for the Verilator top-level test module. After
// reset it holds the design idle until `start`, passes through a warm-up
// window, enables the design (`run`) until the test reports `done`/`error` or
// the watchdog expires, drains for a fixed number of cycles and then raises a
// sticky `finish` that ends the simulation.
//
// Parameters
//   CNT_W          width of the RUN cycle counter
//   WARMUP_CYCLES  cycles spent in WARMUP before RUN (0 skips WARMUP)
//   MAX_CYCLES     watchdog limit in RUN cycles (>= 1, < 2**CNT_W)
//   DRAIN_CYCLES   cycles spent in DRAIN before FINISH (0 skips DRAIN)
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a run (sampled in IDLE only)
//   done       in   1      test complete (sampled in RUN only)
//   error      in   1      test failure  (sampled in RUN only)
//   run        out  1      design enable, high only in RUN
//   finish     out  1      end of simulation, sticky until reset
//   pass       out  1      run ended by done without error
//   timeout    out  1      run ended by the watchdog
//   cycle_cnt  out  CNT_W  RUN cycles elapsed, frozen after RUN
//   state      out  3      state encoding for debug/trace
// -----------------------------------------------------------------------------
module sim_run_ctrl #(
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned WARMUP_CYCLES = 4,
   parameter int unsigned MAX_CYCLES    = 1000,
   parameter int unsigned DRAIN_CYCLES  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             done,
   input  logic             error,
   output logic             run,
   output logic             finish,
   output logic             pass,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WARMUP = 3'd1,
      S_RUN    = 3'd2,
      S_DRAIN  = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   // One window counter serves both WARMUP and DRAIN; it only has to reach
   // the larger window length minus one.
   localparam int unsigned WIN_MAX = (WARMUP_CYCLES > DRAIN_CYCLES) ? WARMUP_CYCLES : DRAIN_CYCLES;
   localparam int unsigned WIN_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

   localparam logic [WIN_W-1:0] WARM_LAST  = (WARMUP_CYCLES > 0) ? WIN_W'(WARMUP_CYCLES - 1) : '0;
   localparam logic [WIN_W-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0)  ? WIN_W'(DRAIN_CYCLES - 1)  : '0;
   localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_CYCLES - 1);

   state_t           r_state;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic             r_run;
   logic             r_finish;
   logic             r_pass;
   logic             r_timeout;

   logic             w_run_exit;

   // Any of the three exit conditions ends RUN on this edge; which one wins
   // is resolved when pass/timeout are registered.
   assign w_run_exit = error | done | (r_cycle_cnt == MAX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_win_cnt   <= '0;
         r_cycle_cnt <= '0;
         r_run       <= 1'b0;
         r_finish    <= 1'b0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (WARMUP_CYCLES == 0) begin
                     r_state     <= S_RUN;
                     r_run       <= 1'b1;
                     r_cycle_cnt <= '0;
                  end else begin
                     r_state   <= S_WARMUP;
                     r_win_cnt <= '0;
                  end
               end
            end

            S_WARMUP: begin
               if (r_win_cnt == WARM_LAST) begin
                  r_state     <= S_RUN;
                  r_run       <= 1'b1;
                  r_cycle_cnt <= '0;
               end else begin
                  r_win_cnt <= r_win_cnt + WIN_W'(1);
               end
            end

            S_RUN: begin
               // The exit edge still counts as a RUN cycle, so the final
               // count equals the number of cycles run was high.
               r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
               if (w_run_exit) begin
                  r_run     <= 1'b0;
                  // error dominates done; done on the watchdog cycle is a pass.
                  r_pass    <= done & ~error;
                  r_timeout <= ~done & ~error;
                  if (DRAIN_CYCLES == 0) begin
                     r_state  <= S_FINISH;
                     r_finish <= 1'b1;
                  end else begin
                     r_state   <= S_DRAIN;
                     r_win_cnt <= '0;
                  end
               end
            end

            S_DRAIN: begin
               if (r_win_cnt == DRAIN_LAST) begin
                  r_state  <= S_FINISH;
                  r_finish <= 1'b1;
               end else begin
                  r_win_cnt <= r_win_cnt + WIN_W'(1);
               end
            end

            S_FINISH: begin
               r_finish <= 1'b1;
            end

            default: begin
               // Illegal encodings fall back to a clean IDLE.
               r_state   <= S_IDLE;
               r_win_cnt <= '0;
               r_run     <= 1'b0;
               r_finish  <= 1'b0;
               r_pass    <= 1'b0;
               r_timeout <= 1'b0;
            end
         endcase
      end
   end

   assign run       = r_run;
   assign finish    = r_finish;
   assign pass      = r_pass;
   assign timeout   = r_timeout;
   assign cycle_cnt = r_cycle_cnt;
   assign state     = r_state;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_run_ctrl
//
// Bench for sim_run_ctrl. Three instances cover the default windows, a short
// watchdog and zero-length WARMUP/DRAIN windows. Each table record describes
// one run; its expected outcome is queued when the run starts and checked
// against what the selected instance produces once finish rises.
// -----------------------------------------------------------------------------
module tb_sim_run_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic done  = 1'b0;
   logic error = 1'b0;

   logic        run_a     [3];
   logic        finish_a  [3];
   logic        pass_a    [3];
   logic        timeout_a [3];
   logic [31:0] cnt_a     [3];
   logic [2:0]  st_a      [3];

   sim_run_ctrl #(.CNT_W(32), .WARMUP_CYCLES(4), .MAX_CYCLES(1000), .DRAIN_CYCLES(8)) u_def (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done), .error(error),
      .run(run_a[0]), .finish(finish_a[0]), .pass(pass_a[0]), .timeout(timeout_a[0]),
      .cycle_cnt(cnt_a[0]), .state(st_a[0]));

   sim_run_ctrl #(.CNT_W(32), .WARMUP_CYCLES(4), .MAX_CYCLES(16), .DRAIN_CYCLES(8)) u_wd (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done), .error(error),
      .run(run_a[1]), .finish(finish_a[1]), .pass(pass_a[1]), .timeout(timeout_a[1]),
      .cycle_cnt(cnt_a[1]), .state(st_a[1]));

   sim_run_ctrl #(.CNT_W(32), .WARMUP_CYCLES(0), .MAX_CYCLES(20), .DRAIN_CYCLES(0)) u_zero (
      .clk(clk), .rst_n(rst_n), .start(start), .done(done), .error(error),
      .run(run_a[2]), .finish(finish_a[2]), .pass(pass_a[2]), .timeout(timeout_a[2]),
      .cycle_cnt(cnt_a[2]), .state(st_a[2]));

   int checks = 0;
   int errors = 0;

   typedef struct {
      int sel;      // 0 default, 1 watchdog 16, 2 zero windows (max 20)
      int done_k;   // RUN cycle carrying done (0 = never)
      int err_k;    // RUN cycle carrying error (0 = never)
      bit noise;    // drive start/done/error where they must be ignored
      int exp_cnt;
      bit exp_pass;
      bit exp_to;
   } vec_t;

   typedef struct {
      int cnt;
      bit pass;
      bit to;
      int warm;
      int runlen;
      int drain;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[11];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_scn(input vec_t v);
      exp_t e;
      exp_t got;
      int   n;
      int   s;
      s = v.sel;

      rst_n = 1'b0; start = 1'b0; done = 1'b0; error = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", st_a[s], 0);
      chk("reset_outs", {run_a[s], finish_a[s], pass_a[s], timeout_a[s]}, 0);
      chk("reset_cnt", cnt_a[s], 0);
      rst_n = 1'b1;
      @(negedge clk);

      if (v.noise) begin
         done = 1'b1; error = 1'b1;
         @(negedge clk);
         done = 1'b0; error = 1'b0;
         @(negedge clk);
         chk("idle_ignores_done", st_a[s], 0);
      end

      e.cnt    = v.exp_cnt;
      e.pass   = v.exp_pass;
      e.to     = v.exp_to;
      e.warm   = (s == 2) ? 0 : 4;
      e.runlen = v.exp_cnt;
      e.drain  = (s == 2) ? 0 : 8;
      sbq.push_back(e);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      n = 0;
      while (!run_a[s] && n < 100) begin
         if (v.noise) begin done = 1'b1; error = 1'b1; end
         n++;
         @(negedge clk);
      end
      done = 1'b0; error = 1'b0;
      got.warm = n;

      n = 0;
      while (run_a[s] && n < 2000) begin
         n++;
         start = v.noise;
         done  = (n == v.done_k);
         error = (n == v.err_k);
         @(negedge clk);
      end
      done = 1'b0; error = 1'b0;
      got.runlen = n;
      got.cnt    = int'(cnt_a[s]);

      n = 0;
      while (!finish_a[s] && n < 100) begin
         if (v.noise) begin done = 1'b1; error = 1'b1; start = 1'b1; end
         n++;
         @(negedge clk);
      end
      got.drain = n;
      got.pass  = pass_a[s];
      got.to    = timeout_a[s];

      if (sbq.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = sbq.pop_front();
         chk("warmup_len", got.warm, e.warm);
         chk("run_len", got.runlen, e.runlen);
         chk("cycle_cnt", got.cnt, e.cnt);
         chk("drain_len", got.drain, e.drain);
         chk("pass", got.pass, e.pass);
         chk("timeout", got.to, e.to);
         chk("pass_timeout_excl", pass_a[s] & timeout_a[s], 0);

         if (v.noise) begin done = 1'b1; error = 1'b1; start = 1'b1; end
         repeat (5) @(negedge clk);
         chk("finish_sticky", finish_a[s], 1);
         chk("finish_state", st_a[s], 4);
         chk("hold_cnt", cnt_a[s], e.cnt);
         chk("hold_pass", pass_a[s], e.pass);
         chk("hold_run_low", run_a[s], 0);
      end
      start = 1'b0; done = 1'b0; error = 1'b0;
   endtask

   // Asynchronous reset while the default instance is in DRAIN.
   task automatic reset_mid_drain();
      int n;
      rst_n = 1'b0; start = 1'b0; done = 1'b0; error = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!run_a[0] && n < 100) begin n++; @(negedge clk); end
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_drain_state", st_a[0], 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", st_a[0], 0);
      chk("async_rst_outs", {run_a[0], finish_a[0], pass_a[0], timeout_a[0]}, 0);
      chk("async_rst_cnt", cnt_a[0], 0);
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{0, 10,  0, 0,   10, 1, 0};
      vecs[1]  = '{0,  5,  5, 0,    5, 0, 0};
      vecs[2]  = '{0,  0,  3, 1,    3, 0, 0};
      vecs[3]  = '{1,  0,  0, 0,   16, 0, 1};
      vecs[4]  = '{1, 16,  0, 0,   16, 1, 0};
      vecs[5]  = '{1, 15,  0, 1,   15, 1, 0};
      vecs[6]  = '{1,  0, 16, 0,   16, 0, 0};
      vecs[7]  = '{2,  7,  0, 1,    7, 1, 0};
      vecs[8]  = '{2,  0,  0, 1,   20, 0, 1};
      vecs[9]  = '{2,  1,  0, 0,    1, 1, 0};
      vecs[10] = '{0,  0,  0, 0, 1000, 0, 1};

      for (int i = 0; i < 11; i++) begin
         run_scn(vecs[i]);
      end

      reset_mid_drain();
      run_scn(vecs[0]);

      chk("scoreboard_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
